mandel_point_engine: RTL and testbench
======================================

// Module: mandel_point_engine
// PURPOSE
//  Computes the Mandelbrot escape count for one pixel: c = start + pixel*scale, iterates z <= z^2 + c in signed fixed point.
//  Successor of the single-point generator: real iteration, pipelined multipliers, abort, escape flag, done pulse.
//  Sits between the pixel scheduler (x/y/start) and the colour mapper (iteration/escaped/done). One clock, one point at a time.
// PARAMETERS
//  WIDTH    32  fixed-point word width (signed two's complement)
//  FRAC     28  fractional bits; integer bits = WIDTH-FRAC-1, must be >= 3
//  XW       12  pixel coordinate width (unsigned)
//  ITW      16  iteration counter width
//  MUL_LAT  2   multiplier pipeline depth in cycles, >= 1
// PORTS
//  CLK             in   1      clock, all logic on rising edge
//  RST             in   1      synchronous reset, active high
//  start           in   1      launch request; accepted only when ready=1
//  abort           in   1      cancel current point, return to IDLE
//  x, y            in   XW     pixel coordinates (unsigned)
//  re_scale        in   WIDTH  real step per pixel (unsigned, FRAC fraction bits)
//  im_scale        in   WIDTH  imaginary step per pixel (unsigned, FRAC fraction bits)
//  re_start        in   WIDTH  real origin (signed fixed point)
//  im_start        in   WIDTH  imaginary origin (signed fixed point)
//  max_iterations  in   ITW    iteration cap
//  ready           out  1      1 in IDLE; engine accepts start
//  done            out  1      one-cycle pulse: result valid
//  escaped         out  1      1 = |z|^2 > 4 reached; 0 = cap reached
//  iteration       out  ITW    escape count; held until next accepted start
// BEHAVIOUR
//  Reset: state IDLE, ready=1, done=0, escaped=0, iteration=0; in-flight point discarded. Reset beats abort and start.
//  States: IDLE -> SETUP -> MUL -> EVAL -> (MUL | IDLE).
//  IDLE: start=1 latches all inputs, ready drops next cycle. While busy, start is ignored (no queueing).
//  SETUP (1 cycle): c_re = re_start + trunc(x*re_scale); c_im = im_start + trunc(y*im_scale); zr=zi=0; n=0.
//   Products are kept at FRAC fraction bits; the low WIDTH bits are kept and wrap silently.
//  MUL (MUL_LAT cycles): zr*zr, zi*zi, zr*zi computed at full 2*WIDTH precision.
//  EVAL (1 cycle), in priority order:
//   mag = zr2+zi2 (2*WIDTH+1 bits); escape iff mag > 4<<(2*FRAC); exactly 4.0 is NOT escape.
//   escape -> iteration=n, escaped=1, go IDLE.
//   else n==max_iterations -> iteration=n, escaped=0, go IDLE.
//   else zr = ((zr2-zi2)>>>FRAC) + c_re, zi = ((2*zr*zi)>>>FRAC) + c_im (truncated to WIDTH); n=n+1; go MUL.
//  Timing (start sampled at cycle t): result k gives done=1 at cycle t+3+MUL_LAT+k*(MUL_LAT+1).
//   ready=1 in the same cycle; a start in the done cycle is accepted (back-to-back points).
//  max_iterations=0: no update; done with iteration=0, escaped=0, unless z0 escapes (never, since z0=0).
//  |c| >= 2 on the real/imag axis: escapes at n=1 unless |c|^2 == 4 exactly.
//  No overflow while |c_re|,|c_im| < 4 with integer bits >= 3; larger c is outside the operating range.
//  abort (not RST): any busy state -> IDLE next cycle, ready=1, no done pulse; iteration/escaped keep prior values.
//   abort in IDLE is a no-op; abort together with start in IDLE: abort wins, start is dropped.
// STRUCTURE
//  Package mandel_pkg: state encoding (IDLE/SETUP/MUL/EVAL), ESCAPE_R2 constant builder, default WIDTH/FRAC/ITW.
//  Sub-module fx_mul_pipe #(WIDTH, MUL_LAT): signed WIDTHxWIDTH -> 2*WIDTH, MUL_LAT register stages.
//   Three instances (zr*zr, zi*zi, zr*zi). Inputs stay stable during MUL; a wait counter counts MUL_LAT.
//  SETUP products use plain multiplies (single cycle, registered).
// TESTING (WIDTH=32, FRAC=28, MUL_LAT=2; done cycle = t+5+3k)
//  1 max_iterations=0, c=0 -> done @t+5, iteration=0, escaped=0.
//  2 re_start=-2.0, re_scale=0.5, x=6, y=0, im_start=0 (c=1+0i), max=100 -> z:0,1,2,5.
//    Expect iteration=3, escaped=1, done @t+14.
//  3 c=-2+0i (|z|^2==4 boundary, never escapes), max=50 -> iteration=50, escaped=0, done @t+155.
//  4 c=3+0i, max=10 -> iteration=1, escaped=1, done @t+8.
//    Then start again in the done cycle with c=0, max=4 -> iteration=4, escaped=0.
//  5 start c=0, max=1000; pulse start again at t+7 (ignored); abort at t+20.
//    Expect ready=1 @t+21, no done, outputs unchanged; the next start runs normally.
//  6 RST asserted mid-run (t+9) -> next cycle ready=1, done=0, iteration=0, escaped=0.
//    Also check the done pulse is exactly 1 cycle wide in all cases.

Source files
------------

// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot point engine: state encoding,
// default word geometry and the escape-radius constant builder.
package mandel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_MUL   = 2'd2,
    ST_EVAL  = 2'd3
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_FRAC  = 28;
  localparam int DEF_ITW   = 16;

  // 4.0 expressed in the squared domain, which carries 2*FRAC fraction bits.
  function automatic logic [127:0] escape_r2(input int frac);
    return 128'd4 << (2 * frac);
  endfunction

endpackage

// File: rtl/fx_mul_pipe.sv
// Signed WIDTH x WIDTH -> 2*WIDTH multiplier with MUL_LAT register stages.
// No flush/stall: the caller holds the operands stable for MUL_LAT cycles.
module fx_mul_pipe #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic                        clk_i,
  input  logic signed [WIDTH-1:0]     a_i,
  input  logic signed [WIDTH-1:0]     b_i,
  output logic signed [2*WIDTH-1:0]   p_o
);

  logic signed [2*WIDTH-1:0] pipe_q [MUL_LAT];

  always_ff @(posedge clk_i) begin
    pipe_q[0] <= a_i * b_i;
    for (int i = 1; i < MUL_LAT; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign p_o = pipe_q[MUL_LAT-1];

endmodule

// File: rtl/mandel_point_engine.sv
// Mandelbrot escape-count engine for one pixel at a time: c = start + pixel*scale,
// z <= z^2 + c until |z|^2 > 4 or the cap; one iteration every MUL_LAT+1 cycles.
module mandel_point_engine
  import mandel_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int FRAC    = DEF_FRAC,
  parameter int XW      = 12,
  parameter int ITW     = DEF_ITW,
  parameter int MUL_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  input  logic [XW-1:0]     x,
  input  logic [XW-1:0]     y,
  input  logic [WIDTH-1:0]  re_scale,
  input  logic [WIDTH-1:0]  im_scale,
  input  logic [WIDTH-1:0]  re_start,
  input  logic [WIDTH-1:0]  im_start,
  input  logic [ITW-1:0]    max_iterations,
  output logic              ready,
  output logic              done,
  output logic              escaped,
  output logic [ITW-1:0]    iteration
);

  localparam int MAGW = 2 * WIDTH + 1;
  localparam logic [127:0]    ESC_FULL = escape_r2(FRAC);
  localparam logic [MAGW-1:0] ESC_R2   = ESC_FULL[MAGW-1:0];
  localparam int WW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_e state_q, state_d;

  logic [XW-1:0]    x_q, y_q;
  logic [WIDTH-1:0] re_scale_q, im_scale_q, re_start_q, im_start_q;
  logic [ITW-1:0]   max_q, n_q, iter_q;
  logic [WW-1:0]    wcnt_q;
  logic signed [WIDTH-1:0] c_re_q, c_im_q, zr_q, zi_q;
  logic done_q, escaped_q;

  logic signed [2*WIDTH-1:0] zr2, zi2, zrzi;
  logic signed [WIDTH-1:0]   c_re_d, c_im_d, zr_d, zi_d;
  logic [MAGW-1:0] mag;
  logic esc_hit, cap_hit, accept, fin;

  fx_mul_pipe #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) u_rr (.clk_i(CLK), .a_i(zr_q), .b_i(zr_q), .p_o(zr2));
  fx_mul_pipe #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) u_ii (.clk_i(CLK), .a_i(zi_q), .b_i(zi_q), .p_o(zi2));
  fx_mul_pipe #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) u_ri (.clk_i(CLK), .a_i(zr_q), .b_i(zi_q), .p_o(zrzi));

  // Integer pixel times FRAC-scaled step is already at FRAC; keep the low word.
  always_comb begin
    c_re_d  = re_start_q + ({{(WIDTH-XW){1'b0}}, x_q} * re_scale_q);
    c_im_d  = im_start_q + ({{(WIDTH-XW){1'b0}}, y_q} * im_scale_q);
    mag     = {1'b0, zr2} + {1'b0, zi2};
    esc_hit = mag > ESC_R2;
    cap_hit = (n_q == max_q);
    zr_d    = WIDTH'((zr2 - zi2) >>> FRAC) + c_re_q;
    zi_d    = WIDTH'((zrzi <<< 1) >>> FRAC) + c_im_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start && !abort) state_d = ST_SETUP;
      ST_SETUP: state_d = abort ? ST_IDLE : ST_MUL;
      ST_MUL: begin
        if (abort)                                state_d = ST_IDLE;
        else if (wcnt_q == WW'(MUL_LAT - 1))      state_d = ST_EVAL;
      end
      ST_EVAL:  state_d = (abort || esc_hit || cap_hit) ? ST_IDLE : ST_MUL;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready  = (state_q == ST_IDLE);
    accept = ready && start && !abort;
    fin    = (state_q == ST_EVAL) && !abort && (esc_hit || cap_hit);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      x_q <= '0; y_q <= '0; max_q <= '0;
      re_scale_q <= '0; im_scale_q <= '0; re_start_q <= '0; im_start_q <= '0;
      c_re_q <= '0; c_im_q <= '0; zr_q <= '0; zi_q <= '0;
      n_q <= '0; wcnt_q <= '0; iter_q <= '0; done_q <= 1'b0; escaped_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        x_q <= x; y_q <= y; max_q <= max_iterations;
        re_scale_q <= re_scale; im_scale_q <= im_scale;
        re_start_q <= re_start; im_start_q <= im_start;
      end
      if (state_q == ST_SETUP) begin
        c_re_q <= c_re_d; c_im_q <= c_im_d;
        zr_q <= '0; zi_q <= '0; n_q <= '0; wcnt_q <= '0;
      end
      if (state_q == ST_MUL) wcnt_q <= wcnt_q + WW'(1);
      if (state_q == ST_EVAL) begin
        wcnt_q <= '0;
        if (fin) begin
          done_q    <= 1'b1;
          escaped_q <= esc_hit;
          iter_q    <= n_q;
        end else if (!abort) begin
          zr_q <= zr_d;
          zi_q <= zi_d;
          n_q  <= n_q + ITW'(1);
        end
      end
    end
  end

  assign done      = done_q;
  assign escaped   = escaped_q;
  assign iteration = iter_q;

endmodule

// File: tb/tb_mandel_point_engine.sv
// Directed and random points against a plain-arithmetic escape-count model.
module tb_mandel_point_engine;

  typedef logic signed [127:0] big_t;
  localparam big_t ESC_LIM = big_t'(4) <<< 56;

  logic        CLK, RST, start, abort;
  logic [11:0] x, y;
  logic [31:0] re_scale, im_scale, re_start, im_start;
  logic [15:0] max_iterations;
  logic        ready, done, escaped;
  logic [15:0] iteration;

  int n_cmp = 0;
  int n_err = 0;

  mandel_point_engine #(.WIDTH(32), .FRAC(28), .XW(12), .ITW(16), .MUL_LAT(2)) dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .x(x), .y(y),
    .re_scale(re_scale), .im_scale(im_scale), .re_start(re_start), .im_start(im_start),
    .max_iterations(max_iterations), .ready(ready), .done(done),
    .escaped(escaped), .iteration(iteration)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_point(input logic [11:0] px, input logic [11:0] py,
                           input logic [31:0] rsc, input logic [31:0] isc,
                           input logic [31:0] rst0, input logic [31:0] ist0,
                           input logic [15:0] mx);
    x = px; y = py; re_scale = rsc; im_scale = isc;
    re_start = rst0; im_start = ist0; max_iterations = mx;
  endtask

  // Escape-count reference: iterate the recurrence directly with wide integers.
  function automatic void ref_point(input logic [11:0] px, input logic [11:0] py,
                                    input logic [31:0] rsc, input logic [31:0] isc,
                                    input logic [31:0] rst0, input logic [31:0] ist0,
                                    input logic [15:0] mx, output int it, output bit esc);
    logic [31:0] cre, cim;
    logic signed [31:0] zr, zi;
    big_t bzr, bzi, r2, i2, ri, nzr, nzi;
    cre = rst0 + {20'd0, px} * rsc;
    cim = ist0 + {20'd0, py} * isc;
    zr = 0; zi = 0; it = 0; esc = 1'b0;
    for (int n = 0; n <= int'(mx); n++) begin
      bzr = big_t'(zr); bzi = big_t'(zi);
      r2 = bzr * bzr; i2 = bzi * bzi; ri = bzr * bzi;
      it = n;
      if (r2 + i2 > ESC_LIM) begin
        esc = 1'b1;
        return;
      end
      if (n == int'(mx)) return;
      nzr = (r2 - i2) >>> 28;
      nzi = (ri <<< 1) >>> 28;
      zr = nzr[31:0] + cre;
      zi = nzi[31:0] + cim;
    end
  endfunction

  // Caller has driven start=1; returns at the negedge where done was seen.
  task automatic run_point(input string tag, input int exp_rel, input int exp_it, input bit exp_esc);
    int rel;
    bit got;
    @(posedge CLK); #1 start = 1'b0;
    got = 1'b0;
    rel = exp_rel + 6;
    for (int r = 1; r <= exp_rel + 5; r++) begin
      @(negedge CLK);
      if (done) begin
        rel = r; got = 1'b1;
        break;
      end
    end
    check({tag, "_latency"}, rel, exp_rel);
    if (got) begin
      check({tag, "_iteration"}, longint'(iteration), exp_it);
      check({tag, "_escaped"}, longint'(escaped), longint'(exp_esc));
      check({tag, "_ready_at_done"}, longint'(ready), 1);
    end
  endtask

  task automatic pulse_end(input string tag);
    @(negedge CLK);
    check({tag, "_done_width"}, longint'(done), 0);
  endtask

  initial begin
    int exp_it;
    bit exp_esc;
    bit seen;
    RST = 1'b1; start = 1'b0; abort = 1'b0;
    set_point(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge CLK);
    check("reset_ready", longint'(ready), 1);
    check("reset_done", longint'(done), 0);
    check("reset_escaped", longint'(escaped), 0);
    check("reset_iteration", longint'(iteration), 0);
    RST = 1'b0;
    @(negedge CLK);

    // max_iterations = 0, c = 0
    set_point(0, 0, 0, 0, 0, 0, 0); start = 1'b1;
    run_point("t1", 5, 0, 1'b0);
    pulse_end("t1");

    // c = 1 + 0i: z = 0,1,2,5
    set_point(6, 0, 32'h0800_0000, 0, 32'hE000_0000, 0, 100); start = 1'b1;
    run_point("t2", 14, 3, 1'b1);
    pulse_end("t2");

    // c = -2 + 0i sits on |z|^2 == 4 forever
    set_point(0, 0, 0, 0, 32'hE000_0000, 0, 50); start = 1'b1;
    run_point("t3", 155, 50, 1'b0);
    pulse_end("t3");

    // c = 3 + 0i, then back-to-back start in the done cycle
    set_point(0, 0, 0, 0, 32'h3000_0000, 0, 10); start = 1'b1;
    run_point("t4a", 8, 1, 1'b1);
    set_point(0, 0, 0, 0, 0, 0, 4); start = 1'b1;
    run_point("t4b", 17, 4, 1'b0);
    pulse_end("t4b");

    // abort mid-run; an extra start while busy is ignored
    set_point(0, 0, 0, 0, 0, 0, 1000); start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    seen = 1'b0;
    for (int r = 1; r <= 20; r++) begin
      @(negedge CLK);
      if (done) seen = 1'b1;
      if (r == 19) check("t5_busy_ready", longint'(ready), 0);
      start = (r == 7);
      abort = (r == 20);
    end
    @(negedge CLK);
    start = 1'b0; abort = 1'b0;
    check("t5_ready_after_abort", longint'(ready), 1);
    check("t5_no_done", longint'(seen | done), 0);
    check("t5_iteration_kept", longint'(iteration), 4);
    check("t5_escaped_kept", longint'(escaped), 0);
    set_point(6, 0, 32'h0800_0000, 0, 32'hE000_0000, 0, 100); start = 1'b1;
    run_point("t5_next", 14, 3, 1'b1);
    pulse_end("t5_next");

    // abort with start in IDLE drops the start
    start = 1'b1; abort = 1'b1;
    @(negedge CLK);
    start = 1'b0; abort = 1'b0;
    check("idle_abort_start_ready", longint'(ready), 1);
    @(negedge CLK);

    // random points against the reference
    for (int k = 0; k < 20; k++) begin
      logic [11:0] px, py;
      logic [31:0] rsc, isc, rs0, is0;
      logic [15:0] mx;
      px  = 12'($urandom_range(0, 4095));
      py  = 12'($urandom_range(0, 4095));
      rsc = 32'($urandom_range(0, 196657));
      isc = 32'($urandom_range(0, 131072));
      rs0 = 32'(-int'($urandom_range(0, 671088640)));
      is0 = 32'(-int'($urandom_range(0, 402653184)));
      mx  = 16'($urandom_range(0, 40));
      ref_point(px, py, rsc, isc, rs0, is0, mx, exp_it, exp_esc);
      set_point(px, py, rsc, isc, rs0, is0, mx); start = 1'b1;
      run_point($sformatf("rnd%0d", k), 5 + 3 * exp_it, exp_it, exp_esc);
      pulse_end($sformatf("rnd%0d", k));
    end

    // synchronous reset mid-run
    set_point(0, 0, 0, 0, 0, 0, 1000); start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    for (int r = 1; r <= 9; r++) begin
      @(negedge CLK);
      if (r == 9) RST = 1'b1;
    end
    @(negedge CLK);
    check("t6_ready", longint'(ready), 1);
    check("t6_done", longint'(done), 0);
    check("t6_iteration", longint'(iteration), 0);
    check("t6_escaped", longint'(escaped), 0);
    RST = 1'b0;
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
